perf_counter_ctrl: RTL and testbench
====================================

Name: perf_counter_ctrl

Overview:
Command-driven controller for the four-counter perf_counters block: hit, miss, read and write.
- Gates the raw event strobes into the counters.
- Issues a one-cycle counter clear.
- Captures all four counts atomically into a shadow bank, then streams them out one word at a time over a valid/ready response port.
- Sits between the cache event sources and perf_counters; the debug/CSR master drives it.

Parameters:
COUNTER_WIDTHS, 32, width of each counter value and of rsp_data
RESET_ENABLE, 1, value of counting_en on reset (1 = counting on, 0 = counting off)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ev_hit, ev_miss, ev_read, ev_write  in  1 each  raw event strobes
count_hit, count_miss, count_read, count_write  out  1 each  gated ticks to perf_counters
counter_clear  out  1  one-cycle pulse; integration ORs it into the perf_counters reset
hit_value, miss_value, read_value, write_value  in  COUNTER_WIDTHS each  live counts from perf_counters
cmd_valid  in  1  command request
cmd_ready  out  1  command accept
cmd_op  in  2  00 ENABLE, 01 DISABLE, 10 DUMP, 11 CLEAR
rsp_valid  out  1  response word valid
rsp_ready  in  1  response word accept
rsp_index  out  2  0 hit, 1 miss, 2 read, 3 write
rsp_data  out  COUNTER_WIDTHS  shadowed count
counting_en  out  1  current enable state
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- Reset values: state IDLE, counting_en = RESET_ENABLE, counter_clear 0, rsp_valid 0, rsp_index 0, shadow bank 0. A reset in any state aborts immediately and rsp_valid drops with it.
- FSM states: IDLE, STREAM, CLEAR.
- cmd_ready is high only in IDLE. A command is accepted on a cycle where cmd_valid and cmd_ready are both high.
- ENABLE / DISABLE:
  - counting_en is updated at the accept edge; the FSM stays in IDLE.
  - An event in the accept cycle is gated by the old enable value.
- Gating is combinational: count_x = ev_x & counting_en & (state != CLEAR).
- DUMP:
  - At the accept edge, all four *_value inputs are latched into the shadow bank, giving one atomic snapshot.
  - The FSM enters STREAM with rsp_index 0 and rsp_valid 1.
  - rsp_data = shadow[rsp_index]. rsp_index and rsp_data hold stable while rsp_valid is high and rsp_ready is low.
  - Each handshake advances the index by 1. The handshake at index 3 returns the FSM to IDLE, and rsp_valid is 0 the following cycle.
  - Live counters keep counting during STREAM; only the shadow bank is read.
  - Best case: accept in cycle N, words in N+1..N+4, cmd_ready high again in N+5.
- CLEAR:
  - On accept, the FSM enters CLEAR for exactly one cycle with counter_clear high and all ticks gated, then returns to IDLE.
  - Accept in cycle N, pulse in N+1, cmd_ready high in N+2.
  - counting_en is unchanged.
- Commands that arrive while busy are stalled by cmd_ready = 0 and are never dropped. Holding cmd_valid is the master's responsibility.
- No arithmetic in this block; wrap-around of the counts is the counters' concern.

Optional Feature:
PERF_CTRL_OVERFLOW_EN
- Defined:
  - Adds output ovf_flags[3:0] (sticky, reset 0) and output rsp_ovf[0:0].
  - ovf_flags[i] sets when counter i's value is all-ones and its gated tick is high in the same cycle, i.e. the counter wraps next edge.
  - The CLEAR op clears ovf_flags at the same edge as counter_clear; a set event in that same cycle is suppressed.
  - DUMP snapshots ovf_flags with the values; rsp_ovf = the snapshotted flag for rsp_index.
- Undefined: the flag logic and both ports are absent.

Decomposition:
- Package perf_ctrl_pkg holds:
  - cmd_op enum (OP_ENABLE, OP_DISABLE, OP_DUMP, OP_CLEAR)
  - FSM state enum
  - NUM_PERF_COUNTERS = 4
  - index constants IDX_HIT..IDX_WRITE
- One sub-module, perf_shadow_bank: a 4 x COUNTER_WIDTHS capture register with a load strobe and a read index.
- The FSM and the gating stay in perf_counter_ctrl.

Test Plan:
- Reset with RESET_ENABLE=1, 10 ev_hit pulses -> count_hit pulses 10 times, counting_en 1, rsp_valid 0, cmd_ready 1.
- DISABLE accepted, then 5 ev_read pulses -> no count_read; an ev_read in the accept cycle itself still passes.
- Counts 7/3/12/9, DUMP accepted, events continue during the stream, rsp_ready toggled 1/0 -> words (0,7),(1,3),(2,12),(3,9) in order, stable while stalled, then back to IDLE.
- CLEAR accepted at cycle N with ev_write high at N+1 -> counter_clear high only in N+1, count_write low in N+1, cmd_ready high in N+2.
- Reset asserted mid-STREAM at index 2 -> rsp_valid 0 immediately, state IDLE, next DUMP starts at index 0.
- With PERF_CTRL_OVERFLOW_EN, COUNTER_WIDTHS=4, 16 hits -> ovf_flags[0] 1; DUMP gives rsp_ovf 1 at index 0; CLEAR returns ovf_flags to 0.

Source files
------------

// File: rtl/perf_ctrl_pkg.sv
// perf_ctrl_pkg
// Shared types and constants for the perf_counters command controller:
// command opcodes, FSM state encoding, counter count and counter indices.
package perf_ctrl_pkg;

    localparam int NUM_PERF_COUNTERS = 4;

    localparam logic [1:0] IDX_HIT   = 2'd0;
    localparam logic [1:0] IDX_MISS  = 2'd1;
    localparam logic [1:0] IDX_READ  = 2'd2;
    localparam logic [1:0] IDX_WRITE = 2'd3;

    typedef enum logic [1:0] {
        OP_ENABLE  = 2'b00,
        OP_DISABLE = 2'b01,
        OP_DUMP    = 2'b10,
        OP_CLEAR   = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_CLEAR  = 2'd2
    } state_e;

endpackage

// File: rtl/perf_shadow_bank.sv
// perf_shadow_bank
// Four-entry capture register holding an atomic snapshot of the counters.
// Ports:
//   clk, reset        clock, asynchronous active-high reset (bank -> 0)
//   load              capture all entries of values on this edge
//   values            packed live counts, entry 0 = hit ... entry 3 = write
//   index             read select
//   data              selected snapshot entry (combinational read)
module perf_shadow_bank
    import perf_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         load,
    input  logic [NUM_PERF_COUNTERS-1:0][WIDTH-1:0]      values,
    input  logic [1:0]                                   index,
    output logic [WIDTH-1:0]                             data
);

    logic [NUM_PERF_COUNTERS-1:0][WIDTH-1:0] bank;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank <= '0;
        end else if (load) begin
            bank <= values;
        end
    end

    assign data = bank[index];

endmodule

// File: rtl/perf_counter_ctrl.sv
// perf_counter_ctrl
// Command-driven controller for the four perf counters (hit, miss, read,
// write): gates raw event strobes, issues a one-cycle counter clear, and
// snapshots all counts for streaming out over a valid/ready response port.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   ev_*                          raw event strobes
//   count_*                       gated ticks to the counters
//   counter_clear                 one-cycle clear pulse
//   *_value                       live counts from the counters
//   cmd_valid/cmd_ready/cmd_op    command port (ENABLE, DISABLE, DUMP, CLEAR)
//   rsp_valid/rsp_ready           response handshake
//   rsp_index/rsp_data            snapshot word index and value
//   counting_en                   current enable state
//   busy                          FSM not in IDLE
// Optional (macro PERF_CTRL_OVERFLOW_EN):
//   ovf_flags                     sticky per-counter wrap flags
//   rsp_ovf                       snapshotted wrap flag for rsp_index
//
// state     | meaning
// ST_IDLE   | accepting commands
// ST_STREAM | returning the four snapshot words, index 0..3
// ST_CLEAR  | counter_clear high, all ticks gated, one cycle
module perf_counter_ctrl
    import perf_ctrl_pkg::*;
#(
    parameter int COUNTER_WIDTHS = 32,
    parameter bit RESET_ENABLE   = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ev_hit,
    input  logic                      ev_miss,
    input  logic                      ev_read,
    input  logic                      ev_write,
    output logic                      count_hit,
    output logic                      count_miss,
    output logic                      count_read,
    output logic                      count_write,
    output logic                      counter_clear,
    input  logic [COUNTER_WIDTHS-1:0] hit_value,
    input  logic [COUNTER_WIDTHS-1:0] miss_value,
    input  logic [COUNTER_WIDTHS-1:0] read_value,
    input  logic [COUNTER_WIDTHS-1:0] write_value,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [1:0]                rsp_index,
    output logic [COUNTER_WIDTHS-1:0] rsp_data,
    output logic                      counting_en,
    output logic                      busy
`ifdef PERF_CTRL_OVERFLOW_EN
    ,
    output logic [3:0]                ovf_flags,
    output logic [0:0]                rsp_ovf
`endif
);

    state_e  state;
    cmd_op_e op;
    logic    accept;
    logic    dump_load;
    logic    gate_open;

    assign op        = cmd_op_e'(cmd_op);
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign dump_load = accept & (op == OP_DUMP);

    // Old counting_en gates events in the accept cycle since it updates on the edge.
    assign gate_open   = counting_en & (state != ST_CLEAR);
    assign count_hit   = ev_hit   & gate_open;
    assign count_miss  = ev_miss  & gate_open;
    assign count_read  = ev_read  & gate_open;
    assign count_write = ev_write & gate_open;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            counting_en   <= RESET_ENABLE;
            counter_clear <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_index     <= IDX_HIT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_ENABLE:  counting_en <= 1'b1;
                            OP_DISABLE: counting_en <= 1'b0;
                            OP_DUMP: begin
                                state     <= ST_STREAM;
                                rsp_valid <= 1'b1;
                                rsp_index <= IDX_HIT;
                            end
                            OP_CLEAR: begin
                                state         <= ST_CLEAR;
                                counter_clear <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_STREAM: begin
                    if (rsp_ready) begin
                        if (rsp_index == IDX_WRITE) begin
                            state     <= ST_IDLE;
                            rsp_valid <= 1'b0;
                            rsp_index <= IDX_HIT;
                        end else begin
                            rsp_index <= rsp_index + 2'd1;
                        end
                    end
                end
                ST_CLEAR: begin
                    state         <= ST_IDLE;
                    counter_clear <= 1'b0;
                end
                default: begin
                    state         <= ST_IDLE;
                    counter_clear <= 1'b0;
                    rsp_valid     <= 1'b0;
                end
            endcase
        end
    end

    perf_shadow_bank #(
        .WIDTH (COUNTER_WIDTHS)
    ) u_shadow (
        .clk    (clk),
        .reset  (reset),
        .load   (dump_load),
        .values ({write_value, read_value, miss_value, hit_value}),
        .index  (rsp_index),
        .data   (rsp_data)
    );

`ifdef PERF_CTRL_OVERFLOW_EN
    logic [3:0] ovf_set;
    logic [3:0] shadow_ovf;

    // A counter at all-ones with a tick this cycle wraps on the next edge.
    assign ovf_set = {count_write & (write_value == '1),
                      count_read  & (read_value  == '1),
                      count_miss  & (miss_value  == '1),
                      count_hit   & (hit_value   == '1)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_flags  <= '0;
            shadow_ovf <= '0;
        end else begin
            // Clear wins over a simultaneous set.
            if (accept && (op == OP_CLEAR)) begin
                ovf_flags <= '0;
            end else begin
                ovf_flags <= ovf_flags | ovf_set;
            end
            if (dump_load) begin
                shadow_ovf <= ovf_flags;
            end
        end
    end

    assign rsp_ovf = shadow_ovf[rsp_index];
`endif

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// tb_perf_counter_ctrl
// Self-checking bench for perf_counter_ctrl: directed scenarios followed by
// randomized traffic, compared every cycle against a queue-based model.
// Also exercises the PERF_CTRL_OVERFLOW_EN build when that macro is defined.
module tb_perf_counter_ctrl;
    import perf_ctrl_pkg::*;

`ifdef PERF_CTRL_OVERFLOW_EN
    localparam int W = 4;
`else
    localparam int W = 32;
`endif
    localparam bit RST_EN = 1'b1;

    logic         clk;
    logic         reset;
    logic         ev_hit, ev_miss, ev_read, ev_write;
    logic         count_hit, count_miss, count_read, count_write;
    logic         counter_clear;
    logic [W-1:0] hit_value, miss_value, read_value, write_value;
    logic         cmd_valid, cmd_ready;
    logic [1:0]   cmd_op;
    logic         rsp_valid, rsp_ready;
    logic [1:0]   rsp_index;
    logic [W-1:0] rsp_data;
    logic         counting_en, busy;
`ifdef PERF_CTRL_OVERFLOW_EN
    logic [3:0]   ovf_flags;
    logic [0:0]   rsp_ovf;
`endif

    perf_counter_ctrl #(
        .COUNTER_WIDTHS (W),
        .RESET_ENABLE   (RST_EN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ev_hit        (ev_hit),
        .ev_miss       (ev_miss),
        .ev_read       (ev_read),
        .ev_write      (ev_write),
        .count_hit     (count_hit),
        .count_miss    (count_miss),
        .count_read    (count_read),
        .count_write   (count_write),
        .counter_clear (counter_clear),
        .hit_value     (hit_value),
        .miss_value    (miss_value),
        .read_value    (read_value),
        .write_value   (write_value),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_index     (rsp_index),
        .rsp_data      (rsp_data),
        .counting_en   (counting_en),
        .busy          (busy)
`ifdef PERF_CTRL_OVERFLOW_EN
        ,
        .ovf_flags     (ovf_flags),
        .rsp_ovf       (rsp_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   idx;
        logic [W-1:0] data;
        logic         ovf;
    } word_t;

    // Reference model: pending response words, clear-cycle flag, enable, flags.
    word_t        m_q[$];
    bit           m_clr;
    bit           m_en;
    logic [3:0]   m_ovf;

    int           n_pass;
    int           n_total;
    int           hit_ticks;
    logic [W-1:0] nv_hit, nv_miss, nv_read, nv_write;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_clr = 1'b0;
        m_en  = RST_EN;
        m_ovf = '0;
    endtask

    // One clock cycle: drive inputs after negedge, check, then advance model at posedge.
    task automatic step(input logic h, input logic m, input logic r, input logic w,
                        input logic cv, input logic [1:0] op, input logic rr);
        bit         idle;
        bit         acc;
        logic [3:0] g;
        logic [3:0] allones;
        word_t      wd;
        @(negedge clk);
        ev_hit = h; ev_miss = m; ev_read = r; ev_write = w;
        cmd_valid = cv; cmd_op = op; rsp_ready = rr;
        hit_value = nv_hit; miss_value = nv_miss; read_value = nv_read; write_value = nv_write;
        #1;
        idle = (m_q.size() == 0) && !m_clr;
        g    = (m_en && !m_clr) ? {w, r, m, h} : 4'b0000;
        chk("cmd_ready",     64'(cmd_ready),     64'(idle));
        chk("busy",          64'(busy),          64'(!idle));
        chk("rsp_valid",     64'(rsp_valid),     64'(m_q.size() != 0));
        chk("counter_clear", 64'(counter_clear), 64'(m_clr));
        chk("counting_en",   64'(counting_en),   64'(m_en));
        chk("count_hit",     64'(count_hit),     64'(g[0]));
        chk("count_miss",    64'(count_miss),    64'(g[1]));
        chk("count_read",    64'(count_read),    64'(g[2]));
        chk("count_write",   64'(count_write),   64'(g[3]));
        if (m_q.size() != 0) begin
            chk("rsp_index", 64'(rsp_index), 64'(m_q[0].idx));
            chk("rsp_data",  64'(rsp_data),  64'(m_q[0].data));
`ifdef PERF_CTRL_OVERFLOW_EN
            chk("rsp_ovf",   64'(rsp_ovf),   64'(m_q[0].ovf));
`endif
        end
`ifdef PERF_CTRL_OVERFLOW_EN
        chk("ovf_flags", 64'(ovf_flags), 64'(m_ovf));
`endif
        if (count_hit) hit_ticks++;
        @(posedge clk);
        acc = cv && idle;
        allones = {nv_write == '1, nv_read == '1, nv_miss == '1, nv_hit == '1};
        if (m_clr) m_clr = 1'b0;
        else if (m_q.size() != 0 && rr) void'(m_q.pop_front());
        if (acc) begin
            case (op)
                2'b00: m_en = 1'b1;
                2'b01: m_en = 1'b0;
                2'b10: begin
                    wd = '{idx: 2'd0, data: nv_hit,   ovf: m_ovf[0]}; m_q.push_back(wd);
                    wd = '{idx: 2'd1, data: nv_miss,  ovf: m_ovf[1]}; m_q.push_back(wd);
                    wd = '{idx: 2'd2, data: nv_read,  ovf: m_ovf[2]}; m_q.push_back(wd);
                    wd = '{idx: 2'd3, data: nv_write, ovf: m_ovf[3]}; m_q.push_back(wd);
                end
                default: m_clr = 1'b1;
            endcase
        end
        if (acc && op == 2'b11) m_ovf = '0;
        else m_ovf = m_ovf | (g & allones);
    endtask

    initial begin
        n_pass = 0; n_total = 0; hit_ticks = 0;
        reset = 1'b1;
        ev_hit = 0; ev_miss = 0; ev_read = 0; ev_write = 0;
        cmd_valid = 0; cmd_op = 2'b00; rsp_ready = 0;
        nv_hit = '0; nv_miss = '0; nv_read = '0; nv_write = '0;
        hit_value = '0; miss_value = '0; read_value = '0; write_value = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_cmd_ready",   64'(cmd_ready),     64'(1));
        chk("rst_rsp_valid",   64'(rsp_valid),     64'(0));
        chk("rst_rsp_index",   64'(rsp_index),     64'(0));
        chk("rst_counting_en", 64'(counting_en),   64'(RST_EN));
        chk("rst_clear",       64'(counter_clear), 64'(0));

        // Ten hit pulses pass while enabled.
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0, 0, 2'b00, 0);
            step(0, 0, 0, 0, 0, 2'b00, 0);
        end
        chk("hit_pulses", 64'(hit_ticks), 64'(10));

        // DISABLE: event in accept cycle still passes, later ones blocked.
        step(0, 0, 1, 0, 1, OP_DISABLE, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 2'b00, 0);
        step(0, 0, 0, 0, 1, OP_ENABLE, 0);

        // DUMP of 7/3/12/9 with live values changing and rsp_ready toggling.
        nv_hit = W'(7); nv_miss = W'(3); nv_read = W'(12); nv_write = W'(9);
        step(1, 0, 0, 0, 1, OP_DUMP, 0);
        for (int i = 0; i < 10; i++) begin
            nv_hit = W'($urandom); nv_miss = W'($urandom);
            nv_read = W'($urandom); nv_write = W'($urandom);
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1, OP_ENABLE, (i % 2) == 0);
        end

        // CLEAR with ev_write high in the pulse cycle.
        step(0, 0, 0, 0, 1, OP_CLEAR, 0);
        step(0, 0, 0, 1, 0, 2'b00, 0);
        step(0, 0, 0, 1, 0, 2'b00, 0);

        // Reset in the middle of a stream at index 2.
        nv_hit = W'(1); nv_miss = W'(2); nv_read = W'(3); nv_write = W'(4);
        step(0, 0, 0, 0, 1, OP_DUMP, 0);
        step(0, 0, 0, 0, 0, 2'b00, 1);
        step(0, 0, 0, 0, 0, 2'b00, 1);
        step(0, 0, 0, 0, 0, 2'b00, 0);
        @(negedge clk);
        reset = 1'b1;
        cmd_valid = 0;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("midrst_busy",      64'(busy),      64'(0));
        chk("midrst_rsp_index", 64'(rsp_index), 64'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        nv_hit = W'(5); nv_miss = W'(6); nv_read = W'(7); nv_write = W'(8);
        step(0, 0, 0, 0, 1, OP_DUMP, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 2'b00, 1);

`ifdef PERF_CTRL_OVERFLOW_EN
        // Hit counter at all-ones with a tick sets its flag; DUMP carries it; CLEAR drops it.
        nv_hit = '1; nv_miss = W'(1); nv_read = W'(1); nv_write = W'(1);
        step(1, 0, 0, 0, 0, 2'b00, 0);
        nv_hit = '0;
        step(0, 0, 0, 0, 1, OP_DUMP, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 2'b00, 1);
        chk("ovf_hit_set", 64'(ovf_flags[0]), 64'(1));
        step(0, 0, 0, 0, 1, OP_CLEAR, 0);
        step(0, 0, 0, 0, 0, 2'b00, 0);
        chk("ovf_cleared", 64'(ovf_flags), 64'(0));
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            nv_hit = W'($urandom); nv_miss = W'($urandom);
            nv_read = W'($urandom); nv_write = W'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                nv_hit = '1; nv_write = '1;
            end
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 3) == 0, 2'($urandom), $urandom_range(0, 2) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
